// File: rtl/gol_pattern_loader_if.sv
// Byte-stream handshake between the host byte source and the pattern loader.
// The source drives data/valid through the master modport; the loader answers
// with ready through the slave modport.
interface gol_pattern_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/gol_pattern_loader.sv
// Game of Life pattern loader.
// Collects a framed byte stream (sync byte, CELLS_X*CELLS_Y/8 payload bytes,
// optional XOR checksum) into a shadow buffer, then copies it onto cells_out
// and strobes overwrite for one cycle so the grid takes the new initial state.
// Optional feature macro: GOL_LOADER_CHECKSUM_EN adds the trailing checksum
// byte, the CHECK state and a functional chk_err pulse.
module gol_pattern_loader #(
    parameter int         CELLS_X   = 32,
    parameter int         CELLS_Y   = 18,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    gol_pattern_loader_if.slave        stream,
    output logic [CELLS_X*CELLS_Y-1:0] cells_out,
    output logic                       overwrite,
    output logic                       busy,
    output logic                       chk_err
);

    localparam int TOTAL = CELLS_X * CELLS_Y;
    localparam int NB    = TOTAL / 8;
    localparam int CNT_W = $clog2(NB);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
`ifdef GOL_LOADER_CHECKSUM_EN
        CHECK  = 3'd2,
`endif
        COMMIT = 3'd3,
        PULSE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [TOTAL-1:0]   shadow;
    logic               in_ready_c;
    logic               accept;
    logic               is_sync;

    // Ready depends on state only, so the source never sees a combinational
    // path from its own valid back to ready.
    assign in_ready_c      = (state != COMMIT) && (state != PULSE);
    assign stream.in_ready = in_ready_c;
    assign accept          = stream.in_valid && in_ready_c;
    assign is_sync         = (stream.in_data == SYNC_BYTE);
    assign busy            = (state != IDLE);

`ifdef GOL_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of payload bytes; cleared when a new frame starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (state == IDLE && accept && is_sync) begin
            csum <= '0;
        end else if (state == LOAD && accept) begin
            csum <= csum ^ stream.in_data;
        end
    end

    // One-cycle error pulse when the trailing byte disagrees with the XOR.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else begin
            chk_err <= (state == CHECK) && accept && (stream.in_data != csum);
        end
    end
`else
    assign chk_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; every waiting state holds until a byte is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_sync) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (accept && cnt == LAST) begin
`ifdef GOL_LOADER_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = COMMIT;
`endif
                end
            end
`ifdef GOL_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_nxt = (stream.in_data == csum) ? COMMIT : IDLE;
                end
            end
`endif
            COMMIT:  state_nxt = PULSE;
            PULSE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Payload byte counter; parks at the last index instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE && accept && is_sync) begin
            cnt <= '0;
        end else if (state == LOAD && accept && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow buffer fills from the top: after NB shifts byte k sits at bits
    // 8k+7..8k, which is exactly the LSB-first row-major cell order.
    always_ff @(posedge clk) begin
        if (state == LOAD && accept) begin
            shadow <= {stream.in_data, shadow[TOTAL-1:8]};
        end
    end

    // Visible grid image: only replaced by a complete, accepted frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cells_out <= '0;
        end else if (state == COMMIT) begin
            cells_out <= shadow;
        end
    end

    // Registered strobe so cells_out has already been stable for a cycle
    // when the grid sees the rising edge of overwrite.
    always_ff @(posedge clk) begin
        if (rst) begin
            overwrite <= 1'b0;
        end else begin
            overwrite <= (state == PULSE);
        end
    end

endmodule

// File: tb/tb_gol_pattern_loader.sv
// Directed testbench for gol_pattern_loader (default 32x18 grid).
module tb_gol_pattern_loader;

    localparam int         CX    = 32;
    localparam int         CY    = 18;
    localparam int         TOTAL = CX * CY;
    localparam int         NB    = TOTAL / 8;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic             clk = 1'b0;
    logic             rst;
    logic [TOTAL-1:0] cells_out;
    logic             overwrite;
    logic             busy;
    logic             chk_err;

    gol_pattern_loader_if bif();

    gol_pattern_loader #(
        .CELLS_X   (CX),
        .CELLS_Y   (CY),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stream    (bif.slave),
        .cells_out (cells_out),
        .overwrite (overwrite),
        .busy      (busy),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int ow_seen = 0;
    int commits = 0;

    logic [7:0]       pl [NB];
    logic [TOTAL-1:0] exp_img;
    logic [TOTAL-1:0] prev_img;

    always @(negedge clk) begin
        if (overwrite === 1'b1) ow_seen++;
    end

    task automatic check1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic checkw(input string tag, input logic [TOTAL-1:0] obs, input logic [TOTAL-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Present one byte and hold it until a rising edge with ready high passes.
    task automatic send_byte(input logic [7:0] b);
        bit   done;
        logic rdy;
        done = 1'b0;
        bif.in_data  = b;
        bif.in_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            rdy = bif.in_ready;
            @(negedge clk);
            if (rdy === 1'b1) done = 1'b1;
        end
        if (!done) check1("send_timeout", 1'b0, 1'b1);
    endtask

    // SYNC + payload from pl[], optionally with idle gaps; returns the XOR.
    task automatic send_payload(input bit gaps, output logic [7:0] cs);
        cs = 8'h00;
        send_byte(SYNC);
        for (int k = 0; k < NB; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bif.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send_byte(pl[k]);
            cs = cs ^ pl[k];
        end
    endtask

    task automatic send_frame(input bit gaps);
        logic [7:0] cs;
        send_payload(gaps, cs);
`ifdef GOL_LOADER_CHECKSUM_EN
        send_byte(cs);
`endif
        bif.in_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the final byte of a frame.
    task automatic check_commit(input logic [TOTAL-1:0] expv);
        check1("e0_ready_low", bif.in_ready, 1'b0);
        check1("e0_busy", busy, 1'b1);
        check1("e0_ow_low", overwrite, 1'b0);
        @(negedge clk);
        checkw("e1_cells", cells_out, expv);
        check1("e1_ow_low", overwrite, 1'b0);
        check1("e1_ready_low", bif.in_ready, 1'b0);
        @(negedge clk);
        check1("e2_ow_high", overwrite, 1'b1);
        check1("e2_ready_high", bif.in_ready, 1'b1);
        check1("e2_busy_low", busy, 1'b0);
        checkw("e2_cells", cells_out, expv);
        @(negedge clk);
        check1("e3_ow_low", overwrite, 1'b0);
        checkw("e3_cells_hold", cells_out, expv);
        commits++;
    endtask

    task automatic clear_pl();
        for (int k = 0; k < NB; k++) pl[k] = 8'h00;
    endtask

    initial begin
        rst          = 1'b1;
        bif.in_data  = 8'h00;
        bif.in_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkw("rst_cells", cells_out, '0);
        check1("rst_ow", overwrite, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_chk_err", chk_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check1("idle_ready", bif.in_ready, 1'b1);
        check1("idle_busy", busy, 1'b0);

        // All-ones frame
        for (int k = 0; k < NB; k++) pl[k] = 8'hFF;
        send_frame(1'b0);
        exp_img = '1;
        check_commit(exp_img);

        // Single bit at cell (0,0)
        clear_pl();
        pl[0] = 8'h01;
        send_frame(1'b0);
        exp_img = '0;
        exp_img[0] = 1'b1;
        check_commit(exp_img);

        // Byte 4 bit 0 is cell (1,0) -> bit 32
        clear_pl();
        pl[4] = 8'h01;
        send_frame(1'b0);
        exp_img = '0;
        exp_img[32] = 1'b1;
        check_commit(exp_img);

`ifdef GOL_LOADER_CHECKSUM_EN
        // Wrong checksum: error pulse, no strobe, image kept
        begin
            logic [7:0] cs;
            int ow_before;
            ow_before = ow_seen;
            clear_pl();
            pl[0] = 8'h01;
            send_payload(1'b0, cs);
            send_byte(8'h5A);
            bif.in_valid = 1'b0;
            check1("bad_chk_err_pulse", chk_err, 1'b1);
            check1("bad_busy", busy, 1'b0);
            @(negedge clk);
            check1("bad_chk_err_one", chk_err, 1'b0);
            repeat (3) @(negedge clk);
            checki("bad_no_ow", ow_seen, ow_before);
            checkw("bad_cells_kept", cells_out, exp_img);
        end
        send_frame(1'b0);
        exp_img = '0;
        exp_img[0] = 1'b1;
        check_commit(exp_img);
`endif

        // Garbage before SYNC is dropped; 0xA5 inside payload is data
        send_byte(8'h00);
        send_byte(8'h13);
        bif.in_valid = 1'b0;
        check1("garbage_not_busy", busy, 1'b0);
        clear_pl();
        pl[10] = 8'hA5;
        pl[NB-1] = 8'h80;
        send_frame(1'b0);
        exp_img = '0;
        exp_img[80] = 1'b1;
        exp_img[82] = 1'b1;
        exp_img[85] = 1'b1;
        exp_img[87] = 1'b1;
        exp_img[TOTAL-1] = 1'b1;
        check_commit(exp_img);

        // Reset after 40 payload bytes
        begin
            int ow_before;
            ow_before = ow_seen;
            send_byte(SYNC);
            for (int k = 0; k < 40; k++) send_byte(8'hFF);
            bif.in_valid = 1'b0;
            check1("mid_busy", busy, 1'b1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checkw("mid_rst_cells", cells_out, '0);
            check1("mid_rst_busy", busy, 1'b0);
            repeat (3) @(negedge clk);
            checki("mid_rst_no_ow", ow_seen, ow_before);
        end
        clear_pl();
        pl[0] = 8'h01;
        send_frame(1'b0);
        exp_img = '0;
        exp_img[0] = 1'b1;
        check_commit(exp_img);

        // Random payload, gapless then with valid gaps
        for (int k = 0; k < NB; k++) pl[k] = 8'($urandom);
        exp_img = '0;
        for (int k = 0; k < NB; k++)
            for (int b = 0; b < 8; b++)
                exp_img[8*k+b] = pl[k][b];
        send_frame(1'b0);
        check_commit(exp_img);
        prev_img = exp_img;
        send_frame(1'b1);
        check_commit(prev_img);

        repeat (3) @(negedge clk);
        checki("total_overwrites", ow_seen, commits);
        check1("final_chk_err", chk_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
